button_event_scheduler: RTL and testbench
=========================================

# button_event_scheduler

Converts the debounced button levels of the game into a serialized stream of press events for the game FSM. Sits between `sync_and_debounce` and game control logic: detects press edges on all `w` buttons, holds them in a pending bitmap, and arbitrates round-robin into a small event FIFO. Events are drained one at a time through a valid/ready handshake, so simultaneous presses are never lost or merged.

## Interface
- `w`, 4: number of buttons; legal range 1..8
- `fifo_depth`, 4: event FIFO entries; power of two, 2..16
- `repeat_delay`, 24'd5_000_000: auto-repeat initial hold time in cycles (used only with the macro)
- `repeat_period`, 24'd1_500_000: auto-repeat interval in cycles (used only with the macro)
- `clk`  input  1  single system clock, all state on rising edge
- `reset`  input  1  reset; one clock; reset is synchronous and active-low
- `sw_db`  input  w  debounced button levels, 1 = pressed; output of `sync_and_debounce`
- `ev_ready`  input  1  consumer accepts the head event this cycle
- `ov_clr`  input  1  clears `ev_overflow`
- `ev_valid`  output  1  FIFO non-empty; head event presented
- `ev_id`  output  idw  index of the button for the head event; idw = (w > 1) ? $clog2(w) : 1
- `ev_overflow`  output  1  sticky; an event was dropped
- `busy`  output  1  any pending bit set or FIFO non-empty

## Operation
- Edge detect: `sw_prev` register (reset 0). `press[i] = sw_db[i] & ~sw_prev[i]`.
- Pending bitmap `pend[w]` (reset 0). Set on `press[i]` (or a repeat injection). Cleared when granted.
- Arbiter: each cycle, if any `pend` bit is set and a push is allowed, grant the first set bit scanning upward from `rr_ptr` with wrap. Push that index into the FIFO, clear its `pend` bit, set `rr_ptr` to (granted+1) mod w. `rr_ptr` resets to 0 and holds when there is no grant.
- Push allowed when FIFO count < `fifo_depth`, or when a pop occurs in the same cycle (count == depth and pop).
- FIFO: pop on `ev_valid & ev_ready`. `ev_id` is the head entry. `ev_id` is don't-care while `ev_valid` = 0, but the RTL drives it to 0.
- Same-bit collision: if `press[i]` and the grant of `i` occur in the same cycle, `pend[i]` stays 1 and there is no overflow. If `press[i]` occurs while `pend[i]` = 1 and `i` is not granted, the press is dropped and `ev_overflow` is set.
- FIFO full with no pop: no grant. Pending bits accumulate. The bitmap absorbs at most one outstanding event per button.
- `ev_overflow`: set wins over `ov_clr` in the same cycle.
- `ev_valid` must not depend combinationally on `ev_ready`.

## Timing
- Reset values: `ev_valid` 0, `ev_id` 0, `ev_overflow` 0, `busy` 0. FIFO empty, `pend` 0, `rr_ptr` 0, `sw_prev` 0. A button already held at reset release produces one event.
- Latency: `sw_db[i]` rises and is first sampled at edge N. `pend[i]` is 1 after edge N. It is granted at edge N+1 if the FIFO has room. `ev_valid` is 1 after edge N+1 (2 cycles).
- Throughput: one push and one pop per cycle. Back-to-back presses on `w` buttons drain in `w` consecutive cycles with `ev_ready` held at 1.
- Reset asserted mid-operation: at the next edge, all state returns to reset values and queued events are discarded.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined: adds an auto-repeat FSM with states IDLE, DELAY and REPEAT, a 24-bit counter, and a tracked id.
  - Any press sets the tracked id to the highest-index pressed button, loads the counter, and moves the FSM to DELAY. This applies in every state.
  - In DELAY or REPEAT, release of the tracked button returns the FSM to IDLE.
  - When the counter reaches `repeat_delay`−1 in DELAY, or `repeat_period`−1 in REPEAT, the FSM injects the tracked id into `pend`. It then moves to REPEAT and clears the counter.
  - An injection into an already-set `pend` bit is dropped silently, with no overflow.
- Macro undefined: no FSM or counter. The only events are press edges, and the parameters are unused.

## Test plan
- Reset, then set `sw_db` = 4'b0100 with `ev_ready` = 1. Expect `ev_valid` = 1 with `ev_id` = 2 exactly 2 cycles after the sample, one cycle long, and `busy` back to 0 one cycle later.
- With `ev_ready` = 0, step `sw_db` from 0 to 4'b1111 in one cycle. Expect 4 FIFO entries in order 0,1,2,3. Then raise `ev_ready` and expect ids 0,1,2,3 on consecutive cycles.
- `fifo_depth` = 4, `ev_ready` = 0: fill the FIFO (4 presses), press button 1 again (pending), then release and press button 1 once more. Expect `ev_overflow` = 1 and 5 events total after draining. Pulse `ov_clr` and expect `ev_overflow` = 0.
- Re-press of button 3 in the exact cycle it is granted: expect no overflow and two id-3 events.
- Round-robin fairness: after granting id 2, press 0 and 3 together. Expect order 3, then 0.
- With the macro, `repeat_delay` = 10 and `repeat_period` = 4: hold button 1 for 30 cycles. Expect the press event, a repeat injected 10 cycles later, then one every 4 cycles. Release and expect no further events. Without the macro, expect exactly 1 event.

Source files
------------

// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Turns debounced button levels into a serialized stream of press events.
//   Rising edges on sw_db set bits in a pending bitmap; a round-robin arbiter
//   moves one pending button per cycle into a small event FIFO. The consumer
//   drains the FIFO one event at a time.
//
//   Optional feature: define BUTTON_AUTOREPEAT_EN to add an auto-repeat FSM.
//   A held button then re-injects its id after repeat_delay cycles, and again
//   every repeat_period cycles until it is released.
//
// Parameters
//   w             number of buttons (1..8)
//   fifo_depth    event FIFO entries (power of two, 2..16)
//   repeat_delay  auto-repeat initial hold time in cycles
//   repeat_period auto-repeat interval in cycles
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-low reset
//   sw_db        debounced button levels, 1 = pressed
//   ev_ready     consumer accepts the head event this cycle
//   ov_clr       clears ev_overflow
//   ev_valid     FIFO non-empty, head event presented on ev_id
//   ev_id        button index of the head event (0 while ev_valid = 0)
//   ev_overflow  sticky, an event was dropped
//   busy         a pending bit is set or the FIFO is non-empty
//   rpt_state    auto-repeat FSM state (0 idle, 1 delay, 2 repeat); 0 when
//                the feature is not built
//
// Handshake: an event transfers on a rising edge where ev_valid and ev_ready
// are both 1. ev_valid is a function of registered state only, so it never
// depends combinationally on ev_ready; the consumer may hold ev_ready high.
module button_event_scheduler #(
  parameter int          w             = 4,
  parameter int          fifo_depth    = 4,
  parameter logic [23:0] repeat_delay  = 24'd5_000_000,
  parameter logic [23:0] repeat_period = 24'd1_500_000,
  localparam int         idw           = (w > 1) ? $clog2(w) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [w-1:0]   sw_db,
  input  logic           ev_ready,
  input  logic           ov_clr,
  output logic           ev_valid,
  output logic [idw-1:0] ev_id,
  output logic           ev_overflow,
  output logic           busy,
  output logic [1:0]     rpt_state
);

  localparam int             aw      = $clog2(fifo_depth);
  localparam logic [aw:0]    DEPTH   = (aw+1)'(fifo_depth);
  localparam logic [idw:0]   W_EXT   = (idw+1)'(w);
  localparam logic [idw-1:0] LAST_ID = idw'(w - 1);

  logic [w-1:0]   sw_prev_q;
  logic [w-1:0]   press;
  logic [w-1:0]   inj;
  logic [w-1:0]   pend_q, pend_d;
  logic [idw-1:0] rr_ptr_q, rr_ptr_d;
  logic [idw-1:0] gnt_idx;
  logic [idw:0]   cand;
  logic           gnt_any, grant, pop, push_ok, ovf_set;
  logic           ovf_q, ovf_d;
  logic [idw-1:0] mem_q [fifo_depth];
  logic [aw-1:0]  rd_ptr_q, wr_ptr_q;
  logic [aw:0]    count_q, count_d;

  assign press       = sw_db & ~sw_prev_q;
  assign ev_valid    = (count_q != '0);
  assign pop         = ev_valid & ev_ready;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_ok     = (count_q < DEPTH) | pop;
  assign grant       = gnt_any & push_ok;
  assign ev_id       = ev_valid ? mem_q[rd_ptr_q] : '0;
  assign busy        = (|pend_q) | ev_valid;
  assign ev_overflow = ovf_q;

  // Round-robin scan: first pending bit at or above rr_ptr, wrapping at w.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < w; k++) begin
      cand = {1'b0, rr_ptr_q} + (idw+1)'(k);
      if (cand >= W_EXT) cand = cand - W_EXT;
      if (!gnt_any && pend_q[cand[idw-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[idw-1:0];
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    rr_ptr_d = rr_ptr_q;
    ovf_set  = 1'b0;
    if (grant) begin
      pend_d[gnt_idx] = 1'b0;
      rr_ptr_d        = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
    end
    // A press into a bit that is pending and not leaving this cycle is lost.
    for (int i = 0; i < w; i++) begin
      if (press[i] && pend_q[i] && !(grant && (gnt_idx == idw'(i)))) ovf_set = 1'b1;
    end
    // Setting after the grant clear keeps the bit when a press collides with
    // its own grant. Repeat injections into a set bit merge silently.
    pend_d  = pend_d | press | inj;
    count_d = count_q + {{aw{1'b0}}, grant} - {{aw{1'b0}}, pop};
    ovf_d   = ovf_set ? 1'b1 : (ov_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_prev_q <= '0;
      pend_q    <= '0;
      rr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sw_prev_q <= sw_db;
      pend_q    <= pend_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (grant) mem_q[wr_ptr_q] <= gnt_idx;
  end

`ifdef BUTTON_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  rpt_state_e     state_q, state_d;
  logic [23:0]    cnt_q, cnt_d;
  logic [idw-1:0] trk_q, trk_d;
  logic [idw-1:0] hi_press;

  always_comb begin
    hi_press = '0;
    for (int i = 0; i < w; i++) begin
      if (press[i]) hi_press = idw'(i);
    end
  end

  // Priority: a new press restarts tracking, then release of the tracked
  // button, then the delay/period expiry that injects a repeat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trk_d   = trk_q;
    inj     = '0;
    if (|press) begin
      state_d = RPT_DELAY;
      cnt_d   = '0;
      trk_d   = hi_press;
    end else if ((state_q != RPT_IDLE) && !sw_db[trk_q]) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else if (((state_q == RPT_DELAY)  && (cnt_q == repeat_delay  - 24'd1)) ||
                 ((state_q == RPT_REPEAT) && (cnt_q == repeat_period - 24'd1))) begin
      inj[trk_q] = 1'b1;
      state_d    = RPT_REPEAT;
      cnt_d      = '0;
    end else if (state_q != RPT_IDLE) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trk_q   <= trk_d;
    end
  end

  assign rpt_state = state_q;
`else
  assign inj       = '0;
  assign rpt_state = 2'b00;

  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{repeat_delay, repeat_period};
`endif

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler (w = 4, fifo_depth = 4, short repeat
// timing). Inputs are driven and outputs sampled on the falling edge.
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_db;
  logic       ev_ready;
  logic       ov_clr;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_overflow;
  logic       busy;
  logic [1:0] rpt_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  button_event_scheduler #(
    .w(4),
    .fifo_depth(4),
    .repeat_delay(24'd10),
    .repeat_period(24'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_db(sw_db),
    .ev_ready(ev_ready),
    .ov_clr(ov_clr),
    .ev_valid(ev_valid),
    .ev_id(ev_id),
    .ev_overflow(ev_overflow),
    .busy(busy),
    .rpt_state(rpt_state)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Returns at a falling edge with reset released; stimulus set right after
  // the call is sampled at the next rising edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; sw_db = '0; ev_ready = 1'b0; ov_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; sw_db = '0; ev_ready = 1'b0; ov_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0 || ev_id !== 2'd0 || ev_overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b id=%0d ovf=%0b busy=%0b, want all 0",
               ev_valid, ev_id, ev_overflow, busy);
    end
    checks++;
    if (rpt_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_rpt_state: got %0d want 0", rpt_state);
    end
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single_press();
    logic [1:0] exp_id;
    apply_reset();
    ev_ready = 1'b1;
    sw_db = 4'b0100;
    exp_q.push_back(2'd2);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      sw_db = '0;
      checks++;
      if (ev_valid !== (t == 2)) begin
        errors++;
        $display("FAIL single_valid t=%0d: got %0b want %0b", t, ev_valid, (t == 2));
      end else if (ev_valid) begin
        exp_id = exp_q.pop_front();
        checks++;
        if (ev_id !== exp_id) begin
          errors++;
          $display("FAIL single_id: got %0d want %0d", ev_id, exp_id);
        end
      end
      if (t == 1 || t == 3) begin
        checks++;
        if (busy !== (t == 1)) begin
          errors++;
          $display("FAIL single_busy t=%0d: got %0b want %0b", t, busy, (t == 1));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_missing: %0d events not seen, want 0", exp_q.size());
    end
  endtask

  task automatic test_burst();
    logic       exp_v;
    logic [1:0] exp_id;
    apply_reset();
    ev_ready = 1'b0;
    sw_db = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    @(negedge clk);
    sw_db = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || busy !== 1'b1 || ev_id !== exp_q[0]) begin
      errors++;
      $display("FAIL burst_hold: valid=%0b busy=%0b id=%0d, want 1 1 %0d",
               ev_valid, busy, ev_id, exp_q[0]);
    end
    ev_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_v = (t < 4);
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL burst_valid t=%0d: got %0b want %0b", t, ev_valid, exp_v);
      end else if (ev_valid) begin
        exp_id = exp_q.pop_front();
        checks++;
        if (ev_id !== exp_id) begin
          errors++;
          $display("FAIL burst_id t=%0d: got %0d want %0d", t, ev_id, exp_id);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_busy_end: got %0b want 0", busy);
    end
  endtask

  task automatic test_overflow();
    logic       exp_v;
    logic [1:0] exp_id;
    apply_reset();
    ev_ready = 1'b0;
    sw_db = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    @(negedge clk);
    sw_db = '0;
    repeat (5) @(negedge clk);
    sw_db = 4'b0010;            // FIFO full: button 1 waits in the bitmap
    exp_q.push_back(2'd1);
    @(negedge clk);
    sw_db = '0;
    @(negedge clk);
    checks++;
    if (ev_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after_pending: got %0b want 0", ev_overflow);
    end
    sw_db = 4'b0010;            // second press while pending: dropped
    @(negedge clk);
    sw_db = '0;
    @(negedge clk);
    checks++;
    if (ev_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %0b want 1", ev_overflow);
    end
    ev_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      exp_v = (t < 5);
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL ovf_drain_valid t=%0d: got %0b want %0b", t, ev_valid, exp_v);
      end else if (ev_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ovf_drain_extra: id=%0d, want no event", ev_id);
        end else begin
          exp_id = exp_q.pop_front();
          checks++;
          if (ev_id !== exp_id) begin
            errors++;
            $display("FAIL ovf_drain_id t=%0d: got %0d want %0d", t, ev_id, exp_id);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ev_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0b want 1", ev_overflow);
    end
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    checks++;
    if (ev_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %0b want 0", ev_overflow);
    end
  endtask

  task automatic test_collision();
    logic       exp_v;
    logic [1:0] exp_id;
    apply_reset();
    ev_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      exp_v = (t >= 2 && t <= 6);
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL coll_valid t=%0d: got %0b want %0b", t, ev_valid, exp_v);
      end else if (ev_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL coll_extra: id=%0d, want no event", ev_id);
        end else begin
          exp_id = exp_q.pop_front();
          checks++;
          if (ev_id !== exp_id) begin
            errors++;
            $display("FAIL coll_id t=%0d: got %0d want %0d", t, ev_id, exp_id);
          end
        end
      end
      // Button 3 is granted on the fifth edge; re-press it for that edge.
      if (t == 0) begin
        sw_db = 4'b1111;
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
      end else if (t == 4) begin
        sw_db = 4'b1111;
        exp_q.push_back(2'd3);
      end else if (t < 4) begin
        sw_db = 4'b0111;
      end else begin
        sw_db = 4'b0000;
      end
      @(negedge clk);
    end
    checks++;
    if (ev_overflow !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL coll_end: ovf=%0b left=%0d, want 0 0", ev_overflow, exp_q.size());
    end
  endtask

  task automatic test_fairness();
    logic       exp_v;
    logic [1:0] exp_id;
    apply_reset();
    ev_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      exp_v = (t == 2 || t == 6 || t == 7);
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL rr_valid t=%0d: got %0b want %0b", t, ev_valid, exp_v);
      end else if (ev_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rr_extra: id=%0d, want no event", ev_id);
        end else begin
          exp_id = exp_q.pop_front();
          checks++;
          if (ev_id !== exp_id) begin
            errors++;
            $display("FAIL rr_id t=%0d: got %0d want %0d", t, ev_id, exp_id);
          end
        end
      end
      sw_db = '0;
      if (t == 0) begin
        sw_db = 4'b0100;
        exp_q.push_back(2'd2);
      end else if (t == 4) begin
        sw_db = 4'b1001;          // pointer sits at 3 after granting 2
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_missing: %0d events not seen, want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    logic       exp_v;
    logic [1:0] exp_id;
    apply_reset();
    ev_ready = 1'b0;
    sw_db = 4'b1111;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sw_db = 4'b0100;              // still held when reset is released
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0 || busy !== 1'b0 || ev_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%0b busy=%0b ovf=%0b, want 0 0 0",
               ev_valid, busy, ev_overflow);
    end
    reset = 1'b1;
    ev_ready = 1'b1;
    exp_q.push_back(2'd2);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      sw_db = '0;
      exp_v = (t == 2);
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL midreset_valid t=%0d: got %0b want %0b", t, ev_valid, exp_v);
      end else if (ev_valid) begin
        exp_id = exp_q.pop_front();
        checks++;
        if (ev_id !== exp_id) begin
          errors++;
          $display("FAIL midreset_id: got %0d want %0d", ev_id, exp_id);
        end
      end
    end
  endtask

  task automatic test_autorepeat();
    logic       exp_v;
    logic [1:0] exp_id;
    logic [1:0] exp_st;
    int         n_ev;
    int         exp_n;
    n_ev = 0;
    apply_reset();
    ev_ready = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
    exp_n = 6;
`else
    exp_n = 1;
`endif
    for (int t = 0; t <= 40; t++) begin
`ifdef BUTTON_AUTOREPEAT_EN
      exp_v = (t == 2) || (t >= 12 && t <= 28 && ((t - 12) % 4) == 0);
      exp_st = (t == 1) ? 2'd1 : (t == 12) ? 2'd2 : 2'd0;
`else
      exp_v = (t == 2);
      exp_st = 2'd0;
`endif
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL rep_valid t=%0d: got %0b want %0b", t, ev_valid, exp_v);
      end else if (ev_valid) begin
        n_ev++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rep_extra t=%0d: id=%0d, want no event", t, ev_id);
        end else begin
          exp_id = exp_q.pop_front();
          checks++;
          if (ev_id !== exp_id) begin
            errors++;
            $display("FAIL rep_id t=%0d: got %0d want %0d", t, ev_id, exp_id);
          end
        end
      end
      if (t == 1 || t == 12 || t == 35) begin
        checks++;
        if (rpt_state !== exp_st) begin
          errors++;
          $display("FAIL rep_state t=%0d: got %0d want %0d", t, rpt_state, exp_st);
        end
      end
      sw_db = (t < 30) ? 4'b0010 : 4'b0000;
      if (t == 0) exp_q.push_back(2'd1);
`ifdef BUTTON_AUTOREPEAT_EN
      if (t >= 10 && t <= 26 && ((t - 10) % 4) == 0) exp_q.push_back(2'd1);
`endif
      @(negedge clk);
    end
    checks++;
    if (n_ev != exp_n) begin
      errors++;
      $display("FAIL rep_count: got %0d events want %0d", n_ev, exp_n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    sw_db = '0;
    ev_ready = 1'b0;
    ov_clr = 1'b0;
    test_reset();
    test_single_press();
    test_burst();
    test_overflow();
    test_collision();
    test_fairness();
    test_mid_reset();
    test_autorepeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
